// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C register-access slave:
//   - default slave address and CRC-8 polynomial
//   - FSM state encoding
//   - crc8_byte(): one-byte CRC-8 update (MSB first, no reflection)
// -----------------------------------------------------------------------------
package i2c_pkg;

  localparam logic [6:0] DEV_ADDR_DEF = 7'h25;
  localparam logic [7:0] CRC_POLY_DEF = 8'h07;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_DEV_ADDR  = 4'd1,
    ST_ACK_DEV   = 4'd2,
    ST_REG_ADDR  = 4'd3,
    ST_ACK_REG   = 4'd4,
    ST_WR_HI     = 4'd5,
    ST_ACK_HI    = 4'd6,
    ST_WR_LO     = 4'd7,
    ST_ACK_LO    = 4'd8,
    ST_WR_CRC    = 4'd9,
    ST_ACK_CRC   = 4'd10,
    ST_RD_HI     = 4'd11,
    ST_MACK_HI   = 4'd12,
    ST_RD_LO     = 4'd13,
    ST_MACK_LO   = 4'd14,
    ST_WAIT_STOP = 4'd15
  } i2c_state_e;

  // Fold one data byte into a running CRC-8, MSB first.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in,
                                           input logic [7:0] data,
                                           input logic [7:0] poly);
    logic [7:0] c;
    c = crc_in ^ data;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) begin
        c = {c[6:0], 1'b0} ^ poly;
      end else begin
        c = {c[6:0], 1'b0};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// -----------------------------------------------------------------------------
// i2c_sync_edge
// Two-flop synchronizer for an asynchronous input followed by a history flop
// so that rising/falling edges are detected on the synchronized level.
// Ports:
//   clk_i   - system clock
//   rst_ni  - synchronous active-low reset (all flops reset to 1, bus idle)
//   async_i - asynchronous input
//   sync_o  - synchronized level
//   rise_o  - one-cycle pulse on synchronized 0->1
//   fall_o  - one-cycle pulse on synchronized 1->0
// -----------------------------------------------------------------------------
module i2c_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchronizer chain plus previous-value flop for edge detection
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/i2c_module.sv
// -----------------------------------------------------------------------------
// i2c_module
// I2C slave bridging to a 16-bit register bank.
//   Write frame: SLA+W, REG, DH, DL, CRC8(REG,DH,DL) -> one write strobe when
//                the CRC matches, CRC byte NACKed otherwise.
//   Read frame : SLA+W, REG, Sr, SLA+R -> one read strobe, then RD_DATA[15:8]
//                and RD_DATA[7:0] are shifted out MSB first.
// Ports:
//   CLK      - system clock (>= 8x SCL)
//   Reset    - synchronous active-low reset
//   SCL/iSDA - I2C bus inputs (asynchronous)
//   oSDA     - open-drain drive, 0 = pull low, 1 = release
//   ADDR     - register address toward bank (held between strobes)
//   WR_DATA  - write data toward bank (held between strobes)
//   RD_DATA  - read data from bank, valid 1 CLK after req
//   RNW      - 1 = read, 0 = write (held between strobes)
//   req      - one-CLK access strobe
//   goodCRC  - one-CLK pulse on a matching write CRC
// -----------------------------------------------------------------------------
module i2c_module
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEF,
  parameter logic [7:0] CRC_POLY = CRC_POLY_DEF
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        SCL,
  input  logic        iSDA,
  output logic        oSDA,
  output logic [7:0]  ADDR,
  output logic [15:0] WR_DATA,
  input  logic [15:0] RD_DATA,
  output logic        RNW,
  output logic        req,
  output logic        goodCRC
);

  // Synchronized bus view
  logic scl_s, scl_rise_s, scl_fall_s;
  logic sda_s, sda_rise_s, sda_fall_s;
  logic start_s, stop_s;
  logic [7:0] byte_s;

  i2c_sync_edge u_scl_sync (
    .clk_i  (CLK),
    .rst_ni (Reset),
    .async_i(SCL),
    .sync_o (scl_s),
    .rise_o (scl_rise_s),
    .fall_o (scl_fall_s)
  );

  i2c_sync_edge u_sda_sync (
    .clk_i  (CLK),
    .rst_ni (Reset),
    .async_i(iSDA),
    .sync_o (sda_s),
    .rise_o (sda_rise_s),
    .fall_o (sda_fall_s)
  );

  assign start_s = sda_fall_s & scl_s;
  assign stop_s  = sda_rise_s & scl_s;

  i2c_state_e  state_q,   state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q,   shift_d;
  logic [15:0] tx_q,      tx_d;
  logic [7:0]  reg_q,     reg_d;
  logic [7:0]  dh_q,      dh_d;
  logic [7:0]  dl_q,      dl_d;
  logic [7:0]  crc_q,     crc_d;
  logic        rw_q,      rw_d;
  logic        rd_pend_q, rd_pend_d;
  logic        sda_q,     sda_d;
  logic [7:0]  addr_q,    addr_d;
  logic [15:0] wdata_q,   wdata_d;
  logic        rnw_q,     rnw_d;
  logic        req_q,     req_d;
  logic        good_q,    good_d;

  // Byte as it stands once the bit being sampled now is shifted in
  assign byte_s = {shift_q[6:0], sda_s};

  // Next-state, datapath and strobe logic
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    reg_d     = reg_q;
    dh_d      = dh_q;
    dl_d      = dl_q;
    crc_d     = crc_q;
    rw_d      = rw_q;
    sda_d     = sda_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rnw_d     = rnw_q;
    req_d     = 1'b0;
    good_d    = 1'b0;
    // Bank data arrives one cycle after a read strobe
    rd_pend_d = req_q & rnw_q;

    if (start_s) begin
      // A fresh transaction forgets the register pointer; a repeated START keeps it
      state_d   = ST_DEV_ADDR;
      bit_cnt_d = 3'd0;
      if (state_q == ST_IDLE) begin
        reg_d = 8'h00;
      end else begin
        reg_d = reg_q;
      end
    end else if (stop_s) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 3'd0;
      reg_d     = 8'h00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end

        // Receiving a byte from the master: release the bus on each SCL fall,
        // sample on each SCL rise, act on the 8th bit.
        ST_DEV_ADDR, ST_REG_ADDR, ST_WR_HI, ST_WR_LO, ST_WR_CRC: begin
          if (scl_fall_s) begin
            sda_d = 1'b1;
          end else if (scl_rise_s) begin
            shift_d   = byte_s;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              case (state_q)
                ST_DEV_ADDR: begin
                  rw_d = byte_s[0];
                  if (byte_s[7:1] == DEV_ADDR) begin
                    state_d = ST_ACK_DEV;
                  end else begin
                    state_d = ST_WAIT_STOP;
                  end
                end
                ST_REG_ADDR: begin
                  reg_d   = byte_s;
                  crc_d   = crc8_byte(8'h00, byte_s, CRC_POLY);
                  state_d = ST_ACK_REG;
                end
                ST_WR_HI: begin
                  dh_d    = byte_s;
                  crc_d   = crc8_byte(crc_q, byte_s, CRC_POLY);
                  state_d = ST_ACK_HI;
                end
                ST_WR_LO: begin
                  dl_d    = byte_s;
                  crc_d   = crc8_byte(crc_q, byte_s, CRC_POLY);
                  state_d = ST_ACK_LO;
                end
                ST_WR_CRC: begin
                  if (byte_s == crc_q) begin
                    addr_d  = reg_q;
                    wdata_d = {dh_q, dl_q};
                    rnw_d   = 1'b0;
                    req_d   = 1'b1;
                    good_d  = 1'b1;
                    state_d = ST_ACK_CRC;
                  end else begin
                    state_d = ST_WAIT_STOP;
                  end
                end
                default: begin
                  state_d = ST_WAIT_STOP;
                end
              endcase
            end else begin
              state_d = state_q;
            end
          end else begin
            state_d = state_q;
          end
        end

        // Entered on the 8th SCL rise: pull low on the following fall, then
        // move on at the 9th rise. The next state releases on the 9th fall.
        ST_ACK_DEV, ST_ACK_REG, ST_ACK_HI, ST_ACK_LO, ST_ACK_CRC: begin
          if (scl_fall_s) begin
            sda_d = 1'b0;
          end else if (scl_rise_s) begin
            bit_cnt_d = 3'd0;
            case (state_q)
              ST_ACK_DEV: begin
                if (rw_q) begin
                  // Strobe the read now so data is loaded before the 9th fall
                  addr_d  = reg_q;
                  rnw_d   = 1'b1;
                  req_d   = 1'b1;
                  state_d = ST_RD_HI;
                end else begin
                  state_d = ST_REG_ADDR;
                end
              end
              ST_ACK_REG: state_d = ST_WR_HI;
              ST_ACK_HI:  state_d = ST_WR_LO;
              ST_ACK_LO:  state_d = ST_WR_CRC;
              default:    state_d = ST_WAIT_STOP;
            endcase
          end else begin
            state_d = state_q;
          end
        end

        // Transmitting a byte: present the next bit on each SCL fall
        ST_RD_HI, ST_RD_LO: begin
          if (scl_fall_s) begin
            sda_d = tx_q[15];
            tx_d  = {tx_q[14:0], 1'b0};
          end else if (scl_rise_s) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == ST_RD_HI) begin
                state_d = ST_MACK_HI;
              end else begin
                state_d = ST_MACK_LO;
              end
            end else begin
              state_d = state_q;
            end
          end else begin
            state_d = state_q;
          end
        end

        // Master acknowledge slot: release, then read the master's answer
        ST_MACK_HI, ST_MACK_LO: begin
          if (scl_fall_s) begin
            sda_d = 1'b1;
          end else if (scl_rise_s) begin
            bit_cnt_d = 3'd0;
            if ((state_q == ST_MACK_HI) && !sda_s) begin
              state_d = ST_RD_LO;
            end else begin
              state_d = ST_WAIT_STOP;
            end
          end else begin
            state_d = state_q;
          end
        end

        ST_WAIT_STOP: begin
          if (scl_fall_s) begin
            sda_d = 1'b1;
          end else begin
            sda_d = sda_q;
          end
        end

        default: begin
          state_d = ST_IDLE;
          sda_d   = 1'b1;
        end
      endcase
    end

    // Bank data capture takes priority over shifting
    tx_d = rd_pend_q ? RD_DATA : tx_d;
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      tx_q      <= 16'h0000;
      reg_q     <= 8'h00;
      dh_q      <= 8'h00;
      dl_q      <= 8'h00;
      crc_q     <= 8'h00;
      rw_q      <= 1'b0;
      rd_pend_q <= 1'b0;
      sda_q     <= 1'b1;
      addr_q    <= 8'h00;
      wdata_q   <= 16'h0000;
      rnw_q     <= 1'b1;
      req_q     <= 1'b0;
      good_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      reg_q     <= reg_d;
      dh_q      <= dh_d;
      dl_q      <= dl_d;
      crc_q     <= crc_d;
      rw_q      <= rw_d;
      rd_pend_q <= rd_pend_d;
      sda_q     <= sda_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rnw_q     <= rnw_d;
      req_q     <= req_d;
      good_q    <= good_d;
    end
  end

  assign oSDA    = sda_q;
  assign ADDR    = addr_q;
  assign WR_DATA = wdata_q;
  assign RNW     = rnw_q;
  assign req     = req_q;
  assign goodCRC = good_q;

endmodule

// File: tb/tb_i2c_module.sv
// -----------------------------------------------------------------------------
// tb_i2c_module
// Bit-banged I2C master against i2c_module on a wired-AND SDA line, with a
// small register bank. Expected strobes and expected bus bytes/ACK bits are
// queued by the stimulus; a monitor compares them as the DUT produces them.
// CRC-8 (poly 0x07, init 0) reference values, worked by hand:
//   REG 10 DH BE DL EF -> 0x10:70, ^BE=CE:64, ^EF=8B:B8  => CRC 0xB8
//   REG 22 DH 00 DL 00 -> 0x22:EE, ^00=EE:84, ^00=84:95  => CRC 0x95
// -----------------------------------------------------------------------------
module tb_i2c_module;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        SCL = 1'b1;
  logic        m_sda = 1'b1;
  logic        iSDA;
  logic        oSDA;
  logic [7:0]  ADDR;
  logic [15:0] WR_DATA;
  logic [15:0] RD_DATA = 16'h0000;
  logic        RNW;
  logic        req;
  logic        goodCRC;

  assign iSDA = m_sda & oSDA;

  i2c_module dut (
    .CLK    (CLK),
    .Reset  (Reset),
    .SCL    (SCL),
    .iSDA   (iSDA),
    .oSDA   (oSDA),
    .ADDR   (ADDR),
    .WR_DATA(WR_DATA),
    .RD_DATA(RD_DATA),
    .RNW    (RNW),
    .req    (req),
    .goodCRC(goodCRC)
  );

  always #5 CLK = ~CLK;

  localparam int Q = 50;
  localparam int H = 100;

  // Register bank: answers one cycle after a strobe
  always @(posedge CLK) begin
    if (req && RNW) RD_DATA <= (ADDR == 8'h10) ? 16'h1234 : 16'hA55A;
  end

  typedef struct packed {
    logic        rnw;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic        good;
    logic        chk_wdata;
  } req_t;

  req_t       exp_req_q[$];
  logic [7:0] exp_bus_q[$];
  logic [7:0] obs_bus_q[$];
  string      tag_q[$];

  int checks = 0;
  int errors = 0;

  logic watch = 1'b0;
  logic low_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: strobes and bus observations against the queued expectations
  always @(negedge CLK) begin
    req_t e;
    string t;
    logic [7:0] o;
    logic [7:0] x;
    if (watch && !oSDA) low_seen = 1'b1;
    if (req) begin
      if (exp_req_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req: actual addr=%0h rnw=%0b required no strobe", ADDR, RNW);
      end else begin
        e = exp_req_q.pop_front();
        chk("req_rnw", RNW, e.rnw);
        chk("req_addr", ADDR, e.addr);
        chk("req_goodcrc", goodCRC, e.good);
        if (e.chk_wdata) chk("req_wdata", WR_DATA, e.wdata);
      end
    end else if (goodCRC) begin
      checks++;
      errors++;
      $display("FAIL stray_goodcrc: actual=1 required=0");
    end
    while (obs_bus_q.size() > 0) begin
      o = obs_bus_q.pop_front();
      if (exp_bus_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL bus_unexpected: actual=%0h required none", o);
      end else begin
        x = exp_bus_q.pop_front();
        t = tag_q.pop_front();
        chk(t, o, x);
      end
    end
  end

  task automatic check_reset_values();
    chk("rst_oSDA", oSDA, 1'b1);
    chk("rst_req", req, 1'b0);
    chk("rst_goodCRC", goodCRC, 1'b0);
    chk("rst_RNW", RNW, 1'b1);
    chk("rst_ADDR", ADDR, 8'h00);
    chk("rst_WR_DATA", WR_DATA, 16'h0000);
  endtask

  task automatic reset_pulse();
    Reset = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_reset_values();
    Reset = 1'b1;
  endtask

  task automatic scl_bit(input logic b, output logic s);
    m_sda = b;
    #Q SCL = 1'b1;
    #(H/2) s = iSDA;
    #(H/2) SCL = 1'b0;
    #Q;
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;
    #Q SCL = 1'b1;
    #Q m_sda = 1'b0;
    #Q SCL = 1'b0;
    #Q;
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    #Q SCL = 1'b1;
    #Q m_sda = 1'b1;
    #Q;
    #Q;
  endtask

  // Send a byte; exp_ack 0 = slave ACK expected. rst_at < 8 pulses Reset before that bit.
  task automatic send_byte(input logic [7:0] d, input logic exp_ack, input string tag, input int rst_at);
    logic s;
    for (int i = 0; i < 8; i++) begin
      if (i == rst_at) reset_pulse();
      scl_bit(d[7-i], s);
    end
    exp_bus_q.push_back({7'd0, exp_ack});
    tag_q.push_back(tag);
    scl_bit(1'b1, s);
    obs_bus_q.push_back({7'd0, s});
  endtask

  // Read a byte; mack 1 = master ACKs it
  task automatic recv_byte(input logic [7:0] exp, input logic mack, input string tag);
    logic s;
    logic [7:0] d;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      scl_bit(1'b1, s);
      d = {d[6:0], s};
    end
    exp_bus_q.push_back(exp);
    tag_q.push_back(tag);
    obs_bus_q.push_back(d);
    scl_bit(~mack, s);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b0;
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    check_reset_values();
    Reset = 1'b1;
    repeat (5) @(posedge CLK);

    // Good write frame, then one extra byte that must be NACKed
    exp_req_q.push_back('{rnw: 1'b0, addr: 8'h10, wdata: 16'hBEEF, good: 1'b1, chk_wdata: 1'b1});
    i2c_start();
    send_byte(8'h4A, 1'b0, "w1_sla_ack", 8);
    send_byte(8'h10, 1'b0, "w1_reg_ack", 8);
    send_byte(8'hBE, 1'b0, "w1_dh_ack", 8);
    send_byte(8'hEF, 1'b0, "w1_dl_ack", 8);
    send_byte(8'hB8, 1'b0, "w1_crc_ack", 8);
    send_byte(8'h55, 1'b1, "w1_extra_nack", 8);
    i2c_stop();

    // Same frame with a wrong CRC byte
    i2c_start();
    send_byte(8'h4A, 1'b0, "w2_sla_ack", 8);
    send_byte(8'h10, 1'b0, "w2_reg_ack", 8);
    send_byte(8'hBE, 1'b0, "w2_dh_ack", 8);
    send_byte(8'hEF, 1'b0, "w2_dl_ack", 8);
    send_byte(8'h00, 1'b1, "w2_crc_nack", 8);
    i2c_stop();
    @(negedge CLK);
    chk("hold_ADDR", ADDR, 8'h10);
    chk("hold_WR_DATA", WR_DATA, 16'hBEEF);
    chk("hold_RNW", RNW, 1'b0);

    // Register read through a repeated START
    exp_req_q.push_back('{rnw: 1'b1, addr: 8'h10, wdata: 16'h0000, good: 1'b0, chk_wdata: 1'b0});
    i2c_start();
    send_byte(8'h4A, 1'b0, "r1_slaw_ack", 8);
    send_byte(8'h10, 1'b0, "r1_reg_ack", 8);
    i2c_start();
    send_byte(8'h4B, 1'b0, "r1_slar_ack", 8);
    recv_byte(8'h12, 1'b1, "r1_byte_hi");
    recv_byte(8'h34, 1'b0, "r1_byte_lo");
    i2c_stop();

    // Read with no register byte: address 0; ACK after low byte still ends the read
    exp_req_q.push_back('{rnw: 1'b1, addr: 8'h00, wdata: 16'h0000, good: 1'b0, chk_wdata: 1'b0});
    i2c_start();
    send_byte(8'h4B, 1'b0, "r2_slar_ack", 8);
    recv_byte(8'hA5, 1'b1, "r2_byte_hi");
    recv_byte(8'h5A, 1'b1, "r2_byte_lo");
    recv_byte(8'hFF, 1'b0, "r2_released");
    i2c_stop();

    // Foreign address: never drives the bus
    low_seen = 1'b0;
    watch = 1'b1;
    i2c_start();
    send_byte(8'hA0, 1'b1, "a50_nack", 8);
    send_byte(8'h10, 1'b1, "a50_data_nack", 8);
    i2c_stop();
    watch = 1'b0;
    chk("a50_sda_low_seen", low_seen, 1'b0);

    // Reset pulse in the middle of the DL byte aborts the frame
    i2c_start();
    send_byte(8'h4A, 1'b0, "rst_sla_ack", 8);
    send_byte(8'h10, 1'b0, "rst_reg_ack", 8);
    send_byte(8'hBE, 1'b0, "rst_dh_ack", 8);
    send_byte(8'hEF, 1'b1, "rst_dl_nack", 3);
    send_byte(8'hB8, 1'b1, "rst_crc_nack", 8);
    i2c_stop();

    // STOP right after REG, then a fresh full write
    i2c_start();
    send_byte(8'h4A, 1'b0, "sp_sla_ack", 8);
    send_byte(8'h10, 1'b0, "sp_reg_ack", 8);
    i2c_stop();
    exp_req_q.push_back('{rnw: 1'b0, addr: 8'h22, wdata: 16'h0000, good: 1'b1, chk_wdata: 1'b1});
    i2c_start();
    send_byte(8'h4A, 1'b0, "w3_sla_ack", 8);
    send_byte(8'h22, 1'b0, "w3_reg_ack", 8);
    send_byte(8'h00, 1'b0, "w3_dh_ack", 8);
    send_byte(8'h00, 1'b0, "w3_dl_ack", 8);
    send_byte(8'h95, 1'b0, "w3_crc_ack", 8);
    i2c_stop();

    repeat (50) @(posedge CLK);
    @(negedge CLK);
    chk("req_queue_drained", exp_req_q.size(), 0);
    chk("bus_queue_drained", exp_bus_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
